// File: rtl/data_mem_bridge_if.sv
// Multi-cycle memory bus seen by the data-memory bridge: request/grant
// handshake out, response (valid/error/data) back.
interface data_mem_bridge_if #(
    parameter int BIT_COUNT = 32,
    parameter int WORD_SIZE = 32
);
    logic                   BusReq;
    logic                   BusWe;
    logic [WORD_SIZE/8-1:0] BusBe;
    logic [BIT_COUNT-1:0]   BusAdr;
    logic [WORD_SIZE-1:0]   BusWData;
    logic                   BusGnt;
    logic                   BusRValid;
    logic [WORD_SIZE-1:0]   BusRData;
    logic                   BusErr;

    modport master (
        output BusReq, BusWe, BusBe, BusAdr, BusWData,
        input  BusGnt, BusRValid, BusRData, BusErr
    );

    modport slave (
        input  BusReq, BusWe, BusBe, BusAdr, BusWData,
        output BusGnt, BusRValid, BusRData, BusErr
    );
endinterface

// File: rtl/data_mem_bridge.sv
// Bridges the single-cycle core's data-memory port onto the multi-cycle bus,
// stalling the core until the access completes and flagging faults as pulses.
module data_mem_bridge #(
    parameter int BIT_COUNT      = 32,
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   CoreMemEn,
    input  logic                   CoreMemWrite,
    input  logic [WORD_SIZE/8-1:0] CoreByteEn,
    input  logic [BIT_COUNT-1:0]   CoreMemAdr,
    input  logic [WORD_SIZE-1:0]   CoreMemWriteData,
    output logic [WORD_SIZE-1:0]   CoreMemReadData,
    output logic                   Stall,
    output logic                   MisalignedFault,
    output logic                   BusFault,
    data_mem_bridge_if.master      bus
);
    localparam int BE_W  = WORD_SIZE / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [BE_W-1:0]        be_q, be_d;
    logic [BIT_COUNT-1:0]   adr_q, adr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
    logic                   mis_q, mis_d;
    logic                   fault_q, fault_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic be_legal;
    logic accept;
    logic timeout_hit;
    logic unused_adr_bits;

    // Legal lanes: any single byte, a naturally aligned halfword, or the full word.
    function automatic logic legal_be(input logic [BE_W-1:0] be);
        logic ok;
        ok = (be == {BE_W{1'b1}});
        for (int i = 0; i < BE_W; i++) begin
            if (be == (BE_W'(1) << i)) ok = 1'b1;
        end
        for (int i = 0; i < BE_W / 2; i++) begin
            if (be == (BE_W'(3) << (2 * i))) ok = 1'b1;
        end
        return ok;
    endfunction

    assign be_legal        = legal_be(CoreByteEn);
    assign accept          = (state_q == IDLE) && CoreMemEn && be_legal;
    assign timeout_hit     = ((state_q == REQ) || (state_q == WAIT_RESP)) && (cnt_q >= CNT_LAST);
    assign unused_adr_bits = ^CoreMemAdr[OFF_W-1:0];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (accept) state_d = REQ;
            REQ:       if (timeout_hit) state_d = DONE;
                       else if (bus.BusGnt) state_d = WAIT_RESP;
            WAIT_RESP: if (timeout_hit || bus.BusRValid) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        unique case (state_q)
            IDLE:      Stall = CoreMemEn && be_legal;
            REQ:       Stall = 1'b1;
            WAIT_RESP: Stall = 1'b1;
            default:   Stall = 1'b0;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        fault_d = 1'b0;

        if ((state_q == REQ || state_q == WAIT_RESP) && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d   = 1'b1;
                    we_d    = CoreMemWrite;
                    be_d    = CoreByteEn;
                    adr_d   = {CoreMemAdr[BIT_COUNT-1:OFF_W], {OFF_W{1'b0}}};
                    wdata_d = CoreMemWriteData;
                    cnt_d   = '0;
                end else if (CoreMemEn) begin
                    mis_d = 1'b1;
                end
            end
            REQ: begin
                if (timeout_hit) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    fault_d = 1'b1;
                end else if (bus.BusGnt) begin
                    req_d = 1'b0;
                end
            end
            WAIT_RESP: begin
                if (timeout_hit || (bus.BusRValid && bus.BusErr)) begin
                    rdata_d = '0;
                    fault_d = 1'b1;
                end else if (bus.BusRValid && !we_q) begin
                    rdata_d = bus.BusRData;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
        end
    end

    assign bus.BusReq      = req_q;
    assign bus.BusWe       = we_q;
    assign bus.BusBe       = be_q;
    assign bus.BusAdr      = adr_q;
    assign bus.BusWData    = wdata_q;
    assign CoreMemReadData = rdata_q;
    assign MisalignedFault = mis_q;
    assign BusFault        = fault_q;
endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Sits directly downstream of the single-cycle compute core's data-memory port, between the core and a shared multi-cycle memory bus.
- Consumes the core's MemEn/MemWrite/ByteEn/MemAdr/MemWriteData request and runs a request/grant/response transaction on the bus.
- Returns MemReadData to the core and stalls the core until the access completes.
- Flags illegal byte-enable patterns and bus errors/timeouts as one-cycle fault pulses.

Parameters:
- BIT_COUNT, 32, core datapath/address width (32 or 64).
- WORD_SIZE, 32, memory data width; byte-enable width is WORD_SIZE/8.
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+WAIT_RESP before the access is abandoned.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset; asynchronous, active-high
- CoreMemEn  in  1  core memory access request; held stable by core while Stall=1
- CoreMemWrite  in  1  1=store, 0=load
- CoreByteEn  in  WORD_SIZE/8  lane-positioned byte enables
- CoreMemAdr  in  BIT_COUNT  byte address
- CoreMemWriteData  in  WORD_SIZE  lane-positioned store data
- CoreMemReadData  out  WORD_SIZE  registered load data to core
- Stall  out  1  freezes core PC/register writeback
- MisalignedFault  out  1  one-cycle pulse, illegal byte-enable pattern
- BusFault  out  1  one-cycle pulse, bus error or timeout
- BusReq  out  1  bus request
- BusWe  out  1  bus write enable
- BusBe  out  WORD_SIZE/8  bus byte enables
- BusAdr  out  BIT_COUNT  word-aligned bus address (low log2(WORD_SIZE/8) bits forced 0)
- BusWData  out  WORD_SIZE  bus write data
- BusGnt  in  1  bus accepts request this cycle
- BusRValid  in  1  response valid (acks loads and stores)
- BusRData  in  WORD_SIZE  load response data
- BusErr  in  1  qualifies BusRValid as an error response

Behaviour:
- Reset (async, immediate): state=IDLE.
  - BusReq=0, BusWe=0, BusBe=0, BusAdr=0, BusWData=0.
  - CoreMemReadData=0, MisalignedFault=0, BusFault=0, timeout counter=0.
- States: IDLE, REQ, WAIT_RESP, DONE.
- Legal CoreByteEn (WORD_SIZE=32): 0001, 0010, 0100, 1000, 0011, 1100, 1111; anything else, including 0000, is illegal.
- IDLE:
  - Stall = CoreMemEn & legal pattern (combinational, same cycle).
  - CoreMemEn & legal: capture We/Be/aligned Adr/WData into the bus output registers; go to REQ.
  - CoreMemEn & illegal: no bus transaction; MisalignedFault=1 next cycle for one cycle; Stall=0 so the core retires the instruction; stay in IDLE.
  - BusRValid in IDLE is ignored.
- REQ:
  - BusReq=1; BusWe/BusBe/BusAdr/BusWData are held stable until grant; Stall=1.
  - On BusGnt: BusReq drops at the next edge; go to WAIT_RESP.
  - BusRValid in REQ is ignored; the earliest response is one cycle after grant.
- WAIT_RESP:
  - Stall=1.
  - BusRValid & !BusErr: load captures BusRData into CoreMemReadData; store leaves it unchanged. Go to DONE.
  - BusRValid & BusErr: CoreMemReadData=0; BusFault pulses one cycle; go to DONE.
- DONE: Stall=0 for exactly one cycle (core retires); unconditionally return to IDLE. A new request is sampled in IDLE on the following cycle.
- Timeout:
  - Counter clears on IDLE->REQ and increments each cycle in REQ or WAIT_RESP.
  - When it reaches TIMEOUT_CYCLES: BusReq=0, CoreMemReadData=0, BusFault pulse, go to DONE.
  - A later stray BusRValid is ignored.
  - Counter saturates, no wrap.
- Minimum latency with zero-wait bus (Gnt in first REQ cycle, RValid next cycle): 3 stall cycles. IDLE(stall) -> REQ -> WAIT_RESP -> DONE(no stall).
- Simultaneous BusGnt and timeout in the same cycle: timeout wins.
- Reset mid-transaction: outputs return to reset values asynchronously; the outstanding response is discarded.
- CoreMemReadData holds its last value except on load completion, error, or timeout.
- BIT_COUNT=64: address width follows BIT_COUNT; data remains WORD_SIZE.

Test Plan:
- Load, Adr=0x1003, Be=1000, Gnt first REQ cycle, RValid next with RData=0xAABBCCDD -> BusAdr=0x1000, BusWe=0, Stall high 3 cycles, CoreMemReadData=0xAABBCCDD in DONE, no faults.
- Store, Adr=0x2000, Be=1111, WData=0x12345678, Gnt delayed 4 cycles -> BusReq/BusWData/BusBe stable for 4 cycles, BusWe=1, CoreMemReadData unchanged, Stall low only in DONE.
- CoreByteEn=0101 or 0000 with CoreMemEn=1 -> no BusReq, Stall=0, MisalignedFault pulses exactly one cycle.
- Load with BusRValid+BusErr, TIMEOUT_CYCLES=8 and Gnt never asserted -> error case: CoreMemReadData=0 and one BusFault pulse; timeout case: BusReq drops after 8 cycles, BusFault pulses, DONE reached.
- Reset asserted mid-WAIT_RESP, then BusRValid=1 after release -> all outputs 0 immediately, state IDLE, response ignored, CoreMemReadData stays 0.
- Back-to-back loads (CoreMemEn held high across DONE with new address 0x3000) -> second BusReq begins two cycles after first DONE, two distinct bus transactions, no re-issue of the first.
